// File: rtl/branch_resolve.sv
// Branch resolution: evaluates bne/blt/jump candidates, issues a held
// redirect to fetch until acknowledged, then a fixed run of flush cycles.
module branch_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_pc,
    input  logic [16:0] in_imm,
    input  logic [26:0] in_jtarget,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack,
    output logic        flush,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
);

    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] taken_count_q, taken_count_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        ne, lt, taken;
    logic [31:0] target;

    // Resolve the candidate: signed compare avoids the overflow trap of a-b.
    always_comb begin
        ne     = (in_a != in_b);
        lt     = ($signed(in_a) < $signed(in_b));
        taken  = ((in_op == 2'b01) && ne) || ((in_op == 2'b10) && lt) || (in_op == 2'b11);
        target = (in_op == 2'b11) ? {5'b0, in_jtarget}
                                  : in_pc + 32'd1 + {{15{in_imm[16]}}, in_imm};
    end

    // Next-state and counter update for IDLE -> REDIRECT -> FLUSH -> IDLE.
    always_comb begin
        state_d        = state_q;
        redirect_pc_d  = redirect_pc_q;
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;
        cnt_d          = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_op != 2'b00)
                        branch_count_d = branch_count_q + 32'd1;
                    if (taken) begin
                        redirect_pc_d = target;
                        taken_count_d = taken_count_q + 32'd1;
                        state_d       = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ack) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                // The count includes the current cycle, so leave on 1.
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            redirect_pc_q  <= 32'd0;
            branch_count_q <= 32'd0;
            taken_count_q  <= 32'd0;
            cnt_q          <= 4'd0;
        end else begin
            state_q        <= state_d;
            redirect_pc_q  <= redirect_pc_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
            cnt_q          <= cnt_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign redirect     = (state_q == REDIRECT);
    assign flush        = (state_q != IDLE);
    assign redirect_pc  = redirect_pc_q;
    assign branch_count = branch_count_q;
    assign taken_count  = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: default instance (2 flush cycles) plus a
// zero-flush instance for the counter-wrap and direct-return cases.
module tb_branch_resolve;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_valid0, ack, ack0;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b, in_pc;
    logic [16:0] in_imm;
    logic [26:0] in_jtarget;

    logic        in_ready, redirect, flush;
    logic [31:0] redirect_pc, branch_count, taken_count;
    logic        in_ready0, redirect0, flush0;
    logic [31:0] redirect_pc0, branch_count0, taken_count0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    branch_resolve #(.FLUSH_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm),
        .in_jtarget(in_jtarget), .redirect(redirect), .redirect_pc(redirect_pc),
        .redirect_ack(ack), .flush(flush), .branch_count(branch_count),
        .taken_count(taken_count)
    );

    branch_resolve #(.FLUSH_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm),
        .in_jtarget(in_jtarget), .redirect(redirect0), .redirect_pc(redirect_pc0),
        .redirect_ack(ack0), .flush(flush0), .branch_count(branch_count0),
        .taken_count(taken_count0)
    );

    // Present one candidate for a single edge; called at a negedge.
    task automatic send(input bit d0, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc,
                        input logic [16:0] imm, input logic [26:0] jt);
        in_op = op; in_a = a; in_b = b; in_pc = pc; in_imm = imm; in_jtarget = jt;
        if (d0) in_valid0 = 1'b1; else in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; in_valid0 = 1'b0;
    endtask

    // Wait (bounded) for redirect, then pop the scoreboard and compare.
    task automatic wait_redirect(input bit d0, input string nm);
        logic [31:0] e;
        int k;
        for (k = 0; k < 8 && !(d0 ? redirect0 : redirect); k++) @(negedge clock);
        n_cmp++;
        if (k == 8) begin
            n_bad++; $display("FAIL %s_timeout: got no redirect want redirect", nm);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if ((d0 ? redirect_pc0 : redirect_pc) !== e) begin
            n_bad++; $display("FAIL %s_pc: got %h want %h", nm, d0 ? redirect_pc0 : redirect_pc, e);
        end
    endtask

    // Hold ack low for hold-1 REDIRECT cycles, ack, then expect 2 flush cycles.
    // Optional junk in_valid during the busy window must be ignored.
    task automatic ack_flush(input int hold, input bit junk, input string nm);
        logic [31:0] pc0;
        pc0 = redirect_pc;
        if (junk) begin in_valid = 1'b1; in_op = 2'b11; in_jtarget = 27'h123; end
        for (int i = 0; i < hold; i++) begin
            n_cmp++;
            if ({redirect, flush, in_ready} !== 3'b110 || redirect_pc !== pc0) begin
                n_bad++; $display("FAIL %s_redir%0d: got r/f/rdy=%b pc=%h want 110 pc=%h",
                                  nm, i, {redirect, flush, in_ready}, redirect_pc, pc0);
            end
            if (i == hold - 1) ack = 1'b1;
            @(negedge clock);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({redirect, flush, in_ready} !== 3'b010) begin
                n_bad++; $display("FAIL %s_flush%0d: got r/f/rdy=%b want 010",
                                  nm, i, {redirect, flush, in_ready});
            end
            if (i == 1) begin in_valid = 1'b0; ack = 1'b0; end
            @(negedge clock);
        end
        n_cmp++;
        if ({redirect, flush, in_ready} !== 3'b001) begin
            n_bad++; $display("FAIL %s_idle: got r/f/rdy=%b want 001", nm, {redirect, flush, in_ready});
        end
    endtask

    task automatic check_counts(input string nm, input logic [31:0] eb, input logic [31:0] et);
        n_cmp++;
        if (branch_count !== eb || taken_count !== et) begin
            n_bad++; $display("FAIL %s_counts: got b=%0d t=%0d want b=%0d t=%0d",
                              nm, branch_count, taken_count, eb, et);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        send(1'b0, 2'b11, 0, 0, 0, 0, 27'h55);   // must not be accepted under reset
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({in_ready, redirect, flush} !== 3'b100 || redirect_pc !== 32'd0) begin
            n_bad++; $display("FAIL reset_state: got rdy/r/f=%b pc=%h want 100 pc=0",
                              {in_ready, redirect, flush}, redirect_pc);
        end
        check_counts("reset", 0, 0);
        n_cmp++;
        if ({in_ready0, redirect0, flush0} !== 3'b100 || taken_count0 !== 32'd0) begin
            n_bad++; $display("FAIL reset_dut0: got rdy/r/f=%b t=%0d want 100 t=0",
                              {in_ready0, redirect0, flush0}, taken_count0);
        end
    endtask

    task automatic test_bne();
        send(1'b0, 2'b01, 5, 5, 32'h10, 17'd4, 0);
        n_cmp++;
        if ({redirect, flush, in_ready} !== 3'b001 || redirect_pc !== 32'd0) begin
            n_bad++; $display("FAIL bne_nt: got r/f/rdy=%b pc=%h want 001 pc=0",
                              {redirect, flush, in_ready}, redirect_pc);
        end
        check_counts("bne_nt", 1, 0);
        exp_q.push_back(32'h0000_000E);
        send(1'b0, 2'b01, 5, 6, 32'h10, 17'h1FFFD, 0);
        wait_redirect(1'b0, "bne_t");
        check_counts("bne_t", 2, 1);
        ack_flush(3, 1'b1, "bne_t");
        check_counts("bne_after", 2, 1);
        n_cmp++;
        if (redirect_pc !== 32'h0E) begin
            n_bad++; $display("FAIL bne_pc_hold: got %h want 0000000e", redirect_pc);
        end
    endtask

    task automatic test_blt();
        exp_q.push_back(32'h0000_0111);
        send(1'b0, 2'b10, 32'h8000_0000, 32'd1, 32'h100, 17'h10, 0);
        wait_redirect(1'b0, "blt_t");
        check_counts("blt_t", 3, 2);
        ack_flush(1, 1'b0, "blt_t");
        send(1'b0, 2'b10, 32'd1, 32'h8000_0000, 32'h100, 17'h10, 0);
        n_cmp++;
        if (redirect !== 1'b0 || redirect_pc !== 32'h111) begin
            n_bad++; $display("FAIL blt_nt: got r=%b pc=%h want 0 pc=00000111", redirect, redirect_pc);
        end
        send(1'b0, 2'b10, 32'h7FFF_FFFF, 32'h8000_0000, 32'h200, 17'h10, 0);
        n_cmp++;
        if (redirect !== 1'b0) begin
            n_bad++; $display("FAIL blt_ovf: got r=%b want 0", redirect);
        end
        check_counts("blt_nt", 5, 2);
    endtask

    // Jump, then a taken bne on the very first IDLE edge, pc wrapping below 0.
    task automatic test_back_to_back();
        exp_q.push_back(32'h07FF_FFFF);
        send(1'b0, 2'b11, 0, 0, 32'h40, 0, 27'h7FF_FFFF);
        wait_redirect(1'b0, "jump");
        check_counts("jump", 6, 3);
        ack_flush(2, 1'b0, "jump");
        exp_q.push_back(32'hFFFF_FFFF);
        send(1'b0, 2'b01, 1, 2, 32'h0, 17'h1FFFE, 0);
        wait_redirect(1'b0, "b2b");
        check_counts("b2b", 7, 4);
        ack_flush(1, 1'b0, "b2b");
        send(1'b0, 2'b00, 1, 2, 32'h300, 17'h5, 27'h5);
        n_cmp++;
        if (redirect !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL op0: got r=%b rdy=%b want 0 1", redirect, in_ready);
        end
        check_counts("op0", 7, 4);
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(32'h0000_0021);
        send(1'b0, 2'b11, 0, 0, 0, 0, 27'h21);
        wait_redirect(1'b0, "rst_redir");
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({redirect, flush, in_ready} !== 3'b001 || redirect_pc !== 32'd0) begin
            n_bad++; $display("FAIL rst_redir: got r/f/rdy=%b pc=%h want 001 pc=0",
                              {redirect, flush, in_ready}, redirect_pc);
        end
        check_counts("rst_redir", 0, 0);
        reset = 1'b1;
        @(negedge clock);
        exp_q.push_back(32'h0000_0022);
        send(1'b0, 2'b11, 0, 0, 0, 0, 27'h22);
        wait_redirect(1'b0, "rst_flush");
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({redirect, flush, in_ready} !== 3'b001) begin
            n_bad++; $display("FAIL rst_flush: got r/f/rdy=%b want 001", {redirect, flush, in_ready});
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_wrap_flush0();
        force dut0.taken_count_q = 32'hFFFF_FFFF;
        #1;
        release dut0.taken_count_q;
        @(negedge clock);
        exp_q.push_back(32'h0000_ABCD);
        send(1'b1, 2'b11, 0, 0, 0, 0, 27'hABCD);
        wait_redirect(1'b1, "wrap");
        n_cmp++;
        if (taken_count0 !== 32'd0 || branch_count0 !== 32'd1) begin
            n_bad++; $display("FAIL wrap_counts: got b=%0d t=%h want b=1 t=00000000",
                              branch_count0, taken_count0);
        end
        ack0 = 1'b1;
        @(negedge clock);
        ack0 = 1'b0;
        n_cmp++;
        if ({redirect0, flush0, in_ready0} !== 3'b001) begin
            n_bad++; $display("FAIL flush0_idle: got r/f/rdy=%b want 001", {redirect0, flush0, in_ready0});
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0; ack = 1'b0; ack0 = 1'b0;
        in_op = 2'b00; in_a = '0; in_b = '0; in_pc = '0; in_imm = '0; in_jtarget = '0;
        repeat (2) @(negedge clock);
        test_reset();
        test_bne();
        test_blt();
        test_back_to_back();
        test_reset_mid();
        test_wrap_flush0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of flush cycles issued after a redirect is acknowledged (legal 0..15).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 SHALL have port in_valid  input  1  branch-candidate instruction present.
REQ-005 SHALL have port in_ready  output  1  block can accept a candidate this cycle.
REQ-006 SHALL have port in_op  input  2  00 non-branch, 01 bne, 10 blt, 11 unconditional jump.
REQ-007 SHALL have port in_a  input  32  $rd operand value.
REQ-008 SHALL have port in_b  input  32  $rs operand value.
REQ-009 SHALL have port in_pc  input  32  PC of the candidate instruction.
REQ-010 SHALL have port in_imm  input  17  signed branch offset N.
REQ-011 SHALL have port in_jtarget  input  27  jump target T.
REQ-012 SHALL have port redirect  output  1  fetch must load redirect_pc.
REQ-013 SHALL have port redirect_pc  output  32  corrected PC.
REQ-014 SHALL have port redirect_ack  input  1  fetch has taken redirect_pc.
REQ-015 SHALL have port flush  output  1  kill the younger instructions in fetch/decode.
REQ-016 SHALL have port branch_count  output  32  resolved conditional branches plus jumps.
REQ-017 SHALL have port taken_count  output  32  redirects issued.

Function
REQ-018 SHALL use the FSM states IDLE, REDIRECT and FLUSH, and all outputs SHALL be driven from registers or the current state.
REQ-019 SHALL drive in_ready=1 only in IDLE, and a candidate SHALL be accepted on an edge with in_valid=1 and in_ready=1.
REQ-020 SHALL compute ne = (in_a != in_b) over all 32 bits.
REQ-021 SHALL compute lt = in_a < in_b as a true two's-complement comparison with no overflow error, for example 0x7FFFFFFF vs 0x80000000 gives lt=0.
REQ-022 SHALL resolve taken = (op==01 & ne) | (op==10 & lt) | (op==11), and op=00 SHALL be consumed with no effect.
REQ-023 SHALL set the target to in_pc + 1 + sign_extend(in_imm) mod 2^32 for op 01 and 10, and to {5'b0, in_jtarget} for op 11.
REQ-024 SHALL, on accepting a candidate with taken=1, register redirect_pc, enter REDIRECT on the next edge and increment taken_count.
REQ-025 SHALL, on accepting a candidate with taken=0, stay in IDLE and leave redirect, flush and redirect_pc unchanged.
REQ-026 SHALL increment branch_count on every accepted candidate with op != 00.
REQ-027 SHALL let branch_count and taken_count wrap from 0xFFFFFFFF to 0.
REQ-028 SHALL, in REDIRECT, hold redirect=1, flush=1 and a stable redirect_pc until redirect_ack=1 is sampled.
REQ-029 SHALL, once redirect_ack is sampled in REDIRECT, enter FLUSH with the down-counter loaded to FLUSH_CYCLES.
REQ-030 SHALL, when redirect_ack is sampled in REDIRECT and FLUSH_CYCLES=0, enter IDLE directly.
REQ-031 SHALL redirect with redirect_ack already high on the first REDIRECT cycle for exactly 1 cycle.
REQ-032 SHALL, in FLUSH, drive redirect=0 and flush=1, decrement the counter each cycle and enter IDLE when the counter reaches 1 (exactly FLUSH_CYCLES flush cycles).
REQ-033 SHALL ignore redirect_ack in IDLE and FLUSH.
REQ-034 SHALL ignore in_valid outside IDLE; upstream holds the instruction because in_ready=0.
REQ-035 SHALL, when in IDLE, accept a new candidate on the first edge after returning to IDLE with no bubble.

Reset
REQ-036 SHALL, on an edge with reset=0, enter IDLE from any state, including mid-REDIRECT or mid-FLUSH, with no pending redirect surviving.
REQ-037 SHALL, on reset, clear redirect, flush, redirect_pc, branch_count, taken_count and the flush counter to 0.
REQ-038 SHALL drive in_ready=1 on the first edge after reset releases.
REQ-039 SHALL accept no candidate on an edge where reset=0.

Verification
REQ-040 SHALL cover: bne with in_a=5, in_b=5, in_pc=0x10, in_imm=4 -> no redirect, branch_count=1, taken_count=0.
REQ-041 SHALL cover: bne with in_a=5, in_b=6, in_pc=0x10, in_imm=-3 (0x1FFFD), redirect_ack delayed 3 cycles -> redirect_pc=0x0E with redirect and flush held 3 cycles, then exactly 2 flush-only cycles, then in_ready=1.
REQ-042 SHALL cover: blt with in_a=0x80000000, in_b=1 -> taken; blt with in_a=1, in_b=0x80000000 -> not taken.
REQ-043 SHALL cover: jump with in_jtarget=0x7FFFFFF -> redirect_pc=0x07FFFFFF, taken_count increments.
REQ-044 SHALL cover: reset=0 asserted during REDIRECT -> next cycle redirect=0, flush=0, in_ready=1, both counters 0.
REQ-045 SHALL cover: taken_count preloaded to 0xFFFFFFFF via 2^32-1 redirects or forced, one more taken branch -> 0, and FLUSH_CYCLES=0 -> IDLE immediately after ack.
